// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST sequencer.
package s298_bist_pkg;

  localparam int unsigned SR_W = 16;
  localparam logic [SR_W-1:0] TAP_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One Fibonacci step: shift left, feedback from the tapped bits into bit 0.
  function automatic logic [SR_W-1:0] sr_shift(input logic [SR_W-1:0] r);
    return {r[SR_W-2:0], ^(r & TAP_MASK)};
  endfunction

endpackage

// File: rtl/s298_bist_sr.sv
// 16-bit shift register used both as the pattern LFSR and as the
// signature MISR. Exposes its next value so the owner can register
// outputs derived from it without an extra cycle of latency.
module s298_bist_sr
  import s298_bist_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SR_W-1:0] load_val,
  input  logic            shift_en,
  input  logic [5:0]      par_in,
  output logic [SR_W-1:0] q,
  output logic [SR_W-1:0] nxt
);

  // Next-value selection: load has priority over shift, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nxt = q;
    if (load) begin
      nxt = load_val;
    end else if (shift_en) begin
      nxt = sr_shift(q) ^ {{(SR_W-6){1'b0}}, par_in};
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/s298_bist_ctrl.sv
// BIST sequencer for the s298 core: holds the core in clear, drives LFSR
// patterns on G1/G2, compacts the core response into a MISR and reports
// completion. Optional golden-signature comparator: S298_BIST_GOLDEN_CMP_EN.
module s298_bist_ctrl
  import s298_bist_pkg::*;
#(
  parameter int unsigned     RST_CYCLES = 2,
  parameter int unsigned     PATTERNS   = 256,
  parameter logic [SR_W-1:0] LFSR_SEED  = 16'hACE1,
  parameter logic [SR_W-1:0] GOLDEN     = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [5:0]      cut_out,
  output logic            cut_g0,
  output logic            cut_g1,
  output logic            cut_g2,
  output logic            busy,
  output logic            done,
  output logic [SR_W-1:0] pat_count,
  output logic [SR_W-1:0] signature,
  output logic            pass
);

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [SR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;
  localparam logic [3:0]      CLR_LAST = 4'(RST_CYCLES - 1);
  localparam logic [SR_W-1:0] PAT_LAST = 16'(PATTERNS - 1);

  state_t          state;
  state_t          next_state;
  logic [3:0]      clr_cnt;
  logic            load_en;
  logic            lfsr_shift;
  logic            misr_cap;
  logic            pc_inc;
  logic [SR_W-1:0] lfsr_q;
  logic [SR_W-1:0] lfsr_nxt;
  logic [SR_W-1:0] misr_q;
  logic [SR_W-1:0] misr_nxt;

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    load_en    = 1'b0;
    lfsr_shift = 1'b0;
    misr_cap   = 1'b0;
    pc_inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          next_state = CLEAR;
          load_en    = 1'b1;
        end
      end
      CLEAR: begin
        if (abort) begin
          next_state = IDLE;
        end else if (clr_cnt == CLR_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          lfsr_shift = 1'b1;
          pc_inc     = 1'b1;
          // The core still shows its cleared response in the first RUN cycle.
          misr_cap   = (pat_count != '0);
          if (pat_count == PAT_LAST) begin
            next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          // Response to the last pattern arrives one cycle late.
          misr_cap   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counters and registered core/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      pat_count <= '0;
      cut_g0    <= 1'b1;
      cut_g1    <= 1'b0;
      cut_g2    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state   <= next_state;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 4'd1 : '0;
      if (load_en) begin
        pat_count <= '0;
      end else if (pc_inc) begin
        pat_count <= pat_count + 16'd1;
      end
      cut_g0 <= (next_state != RUN);
      cut_g1 <= (next_state == RUN) & lfsr_nxt[0];
      cut_g2 <= (next_state == RUN) & lfsr_nxt[1];
      busy   <= (next_state == CLEAR) || (next_state == RUN) || (next_state == FLUSH);
      done   <= (next_state == DONE);
    end
  end

  s298_bist_sr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (SEED_EFF),
    .shift_en (lfsr_shift),
    .par_in   (6'd0),
    .q        (lfsr_q),
    .nxt      (lfsr_nxt)
  );

  s298_bist_sr u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val ('0),
    .shift_en (misr_cap),
    .par_in   (cut_out),
    .q        (misr_q),
    .nxt      (misr_nxt)
  );

  assign signature = misr_q;

  // Only the two low LFSR bits feed the core.
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr_q, lfsr_nxt[SR_W-1:2]};

`ifdef S298_BIST_GOLDEN_CMP_EN
  // Golden compare, latched as the test enters DONE; cleared on start/abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (load_en || (abort && (state != IDLE) && (state != DONE))) begin
      pass <= 1'b0;
    end else if ((state == FLUSH) && (next_state == DONE)) begin
      pass <= (misr_nxt == GOLDEN);
    end
  end
`else
  assign pass = 1'b0;
  logic unused_cmp;
  assign unused_cmp = ^{GOLDEN, misr_nxt};
`endif

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// Self-checking bench for s298_bist_ctrl: three parameterisations share one
// stimulus stream; a cycle-indexed behavioural model predicts every output.
module tb_s298_bist_ctrl;

  localparam int N = 3;
  localparam int          R_TAB    [N] = '{2, 1, 1};
  localparam int          P_TAB    [N] = '{4, 2, 1};
  localparam logic [15:0] SEED_TAB [N] = '{16'h0001, 16'h0000, 16'hACE1};
  localparam logic [15:0] GOLD_TAB [N] = '{16'h0000, 16'h0041, 16'h003F};
`ifdef S298_BIST_GOLDEN_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [5:0] cut_out;
  logic [N-1:0] g0, g1, g2, bsy, dn, ps;
  logic [N-1:0][15:0] pc, sg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  s298_bist_ctrl #(.RST_CYCLES(2), .PATTERNS(4), .LFSR_SEED(16'h0001), .GOLDEN(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_out(cut_out),
    .cut_g0(g0[0]), .cut_g1(g1[0]), .cut_g2(g2[0]), .busy(bsy[0]), .done(dn[0]),
    .pat_count(pc[0]), .signature(sg[0]), .pass(ps[0]));

  s298_bist_ctrl #(.RST_CYCLES(1), .PATTERNS(2), .LFSR_SEED(16'h0000), .GOLDEN(16'h0041)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_out(cut_out),
    .cut_g0(g0[1]), .cut_g1(g1[1]), .cut_g2(g2[1]), .busy(bsy[1]), .done(dn[1]),
    .pat_count(pc[1]), .signature(sg[1]), .pass(ps[1]));

  s298_bist_ctrl #(.RST_CYCLES(1), .PATTERNS(1), .LFSR_SEED(16'hACE1), .GOLDEN(16'h003F)) dut_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_out(cut_out),
    .cut_g0(g0[2]), .cut_g1(g1[2]), .cut_g2(g2[2]), .busy(bsy[2]), .done(dn[2]),
    .pat_count(pc[2]), .signature(sg[2]), .pass(ps[2]));

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Shift rule written from the tap list: taps 15,13,12,10 into bit 0.
  function automatic logic [15:0] spec_shift(input logic [15:0] r, input logic [5:0] par);
    logic fb;
    fb = r[15] ^ r[13] ^ r[12] ^ r[10];
    return {r[14:0], fb} ^ {10'd0, par};
  endfunction

  // Model: m_t is the cycle index since the start edge (1 = first CLEAR cycle).
  bit          m_valid = 1'b0;
  bit          m_act  [N];
  int          m_t    [N];
  logic [15:0] m_pc   [N];
  logic [15:0] m_sig  [N];
  logic [15:0] m_lfsr [N];
  bit          m_pass [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int r, p, t;
      r = R_TAB[i];
      p = P_TAB[i];
      t = m_t[i];
      if (rst) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_pc[i] = '0; m_sig[i] = '0; m_pass[i] = 1'b0; m_lfsr[i] = '0;
      end else if (!m_act[i]) begin
        if (start && !abort) begin
          m_act[i] = 1'b1; m_t[i] = 1; m_pc[i] = '0; m_sig[i] = '0; m_pass[i] = 1'b0;
          m_lfsr[i] = (SEED_TAB[i] == 16'h0000) ? 16'h0001 : SEED_TAB[i];
        end
      end else if (abort && t <= r + p + 1) begin
        m_act[i] = 1'b0;
        m_pass[i] = 1'b0;
      end else begin
        if (t > r && t <= r + p) begin
          if (t > r + 1) m_sig[i] = spec_shift(m_sig[i], cut_out);
          m_pc[i] = 16'(t - r);
          m_lfsr[i] = spec_shift(m_lfsr[i], 6'd0);
        end else if (t == r + p + 1) begin
          m_sig[i] = spec_shift(m_sig[i], cut_out);
          m_pass[i] = CMP_EN && (m_sig[i] == GOLD_TAB[i]);
        end
        if (t == r + p + 2) m_act[i] = 1'b0;
        else m_t[i] = t + 1;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  // Per-cycle comparison of every output of every instance against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        bit run;
        int r, p, t;
        r = R_TAB[i];
        p = P_TAB[i];
        t = m_t[i];
        run = m_act[i] && t > r && t <= r + p;
        check("cut_g0", i, 16'(g0[i]), 16'(!run));
        check("cut_g1", i, 16'(g1[i]), 16'(run & m_lfsr[i][0]));
        check("cut_g2", i, 16'(g2[i]), 16'(run & m_lfsr[i][1]));
        check("busy", i, 16'(bsy[i]), 16'(m_act[i] && t <= r + p + 1));
        check("done", i, 16'(dn[i]), 16'(m_act[i] && t == r + p + 2));
        check("pat_count", i, pc[i], m_pc[i]);
        check("signature", i, sg[i], m_sig[i]);
        check("pass", i, 16'(ps[i]), 16'(m_pass[i]));
      end
    end
  end

  task automatic pin_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check({tag, "_g0"}, i, 16'(g0[i]), 16'd1);
      check({tag, "_out"}, i, 16'({g1[i], g2[i], bsy[i], dn[i], ps[i]}), 16'd0);
      check({tag, "_pc"}, i, pc[i], 16'h0000);
      check({tag, "_sig"}, i, sg[i], 16'h0000);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cut_out = 6'h00;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    pin_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full test with constant response 6'h3F; start sampled at edge 0.
    cut_out = 6'h3F;
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      check("a_busy_tl", 0, 16'(bsy[0]), 16'(c >= 1 && c <= 7));
      check("a_g0_tl", 0, 16'(g0[0]), 16'(!(c >= 3 && c <= 6)));
      check("a_done_tl", 0, 16'(dn[0]), 16'(c == 8));
      if (c == 3) check("a_g1g2_run1", 0, 16'({g1[0], g2[0]}), 16'b10);
      if (c == 4) check("a_g1g2_run2", 0, 16'({g1[0], g2[0]}), 16'b01);
      if (c == 2) check("b_g1g2_run1", 1, 16'({g1[1], g2[1]}), 16'b10);
      if (c == 3) check("b_g1g2_run2", 1, 16'({g1[1], g2[1]}), 16'b01);
      if (c == 2) check("c_g1g2_run1", 2, 16'({g1[2], g2[2]}), 16'b10);
      if (c == 4) check("c_done", 2, 16'(dn[2]), 16'd1);
      if (c == 5) check("b_done", 1, 16'(dn[1]), 16'd1);
      if (c == 8) check("a_pat_count", 0, pc[0], 16'd4);
    end
    check("a_sig", 0, sg[0], 16'h0145);
    check("b_sig", 1, sg[1], 16'h0041);
    check("c_sig", 2, sg[2], 16'h003F);
    check("a_pass", 0, 16'(ps[0]), 16'd0);
    check("b_pass", 1, 16'(ps[1]), 16'(CMP_EN));
    check("c_pass", 2, 16'(ps[2]), 16'(CMP_EN));

    // Varying response vectors.
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
      cut_out = 6'((c * 13 + 5) ^ (c << 3));
    end

    // Start while busy (cycle 2), abort in dut_a's second RUN cycle (cycle 4).
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = (c == 2);
      abort = (c == 4);
      cut_out = 6'(c * 5 + 1);
      if (c == 3) check("a_busy_ign_start", 0, 16'(bsy[0]), 16'd1);
      if (c == 5) begin
        check("a_abort_busy", 0, 16'(bsy[0]), 16'd0);
        check("a_abort_g0", 0, 16'(g0[0]), 16'd1);
        check("a_abort_pass", 0, 16'(ps[0]), 16'd0);
        check("a_abort_pc", 0, pc[0], 16'd1);
      end
      if (c >= 5) check("a_no_done", 0, 16'(dn[0]), 16'd0);
    end

    // start and abort together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < N; i++) check("start_abort_idle", i, 16'({bsy[i], g0[i]}), 16'b01);
    @(negedge clk);

    // Reset in the middle of a test.
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      cut_out = 6'(c + 40);
    end
    rst = 1'b1;
    @(negedge clk);
    pin_reset_state("midrst");
    rst = 1'b0;
    @(negedge clk);

    // Final complete run.
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      cut_out = 6'(c * 11 + 7);
    end
    check("a_final_pc", 0, pc[0], 16'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
